// File: rtl/tt_ternary_weight_loader_pkg.sv
// Shared ternary weight encoding and loader state constants; the multiplier
// imports the same encoding so both sides agree on what a 2-bit field means.
package tt_ternary_weight_loader_pkg;

    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_ILL  = 2'b10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    // The illegal code is stored as zero so the multiplier never sees it.
    function automatic logic [1:0] tern_sanitise(input logic [1:0] f);
        return (f == TERN_ILL) ? TERN_ZERO : f;
    endfunction

endpackage

// File: rtl/tt_ternary_weight_loader_unpack.sv
// Splits one packed weight byte into four sanitised 2-bit ternary fields and
// flags whether any field carried the illegal code.
module tern_byte_unpack
    import tt_ternary_weight_loader_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [7:0] fields,
    output logic       illegal
);

    always_comb begin
        fields  = '0;
        illegal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fields[i*2 +: 2] = tern_sanitise(byte_in[i*2 +: 2]);
            if (byte_in[i*2 +: 2] == TERN_ILL) illegal = 1'b1;
        end
    end

endmodule

// File: rtl/tt_ternary_weight_loader.sv
// Deserialises packed ternary weights into a shadow bank and commits it to the
// active bank only on a multiplier frame boundary (or at once if none is active).
module tt_ternary_weight_loader
    import tt_ternary_weight_loader_pkg::*;
#(
    parameter int InLen  = 16,
    parameter int OutLen = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       load_start,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    input  logic                       frame_boundary,
    output logic [InLen*OutLen*2-1:0]  w_flat,
    output logic                       weights_valid,
    output logic                       busy,
    output logic                       fmt_err
);

    localparam int NBYTES = InLen * OutLen / 4;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int W      = InLen * OutLen * 2;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shadow;
    logic [7:0]    fields;
    logic          illegal;

    tern_byte_unpack u_unpack (
        .byte_in (in_data),
        .fields  (fields),
        .illegal (illegal)
    );

    assign busy = (state != IDLE);

    // Byte k lands at bit k*8 of the shadow because OutLen is a multiple of 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            shadow        <= '0;
            w_flat        <= '0;
            weights_valid <= 1'b0;
            fmt_err       <= 1'b0;
        end else if (en) begin
            if (load_start) begin
                state   <= LOAD;
                cnt     <= '0;
                fmt_err <= 1'b0;
                if (in_valid) begin
                    shadow[7:0] <= fields;
                    cnt         <= CW'(1);
                    fmt_err     <= illegal;
                end
            end else begin
                case (state)
                    LOAD: begin
                        if (in_valid) begin
                            shadow[{cnt, 3'b000} +: 8] <= fields;
                            if (illegal) fmt_err <= 1'b1;
                            if (cnt == LAST) state <= PEND;
                            else             cnt   <= cnt + CW'(1);
                        end
                    end
                    PEND: begin
                        if (frame_boundary || !weights_valid) begin
                            w_flat        <= shadow;
                            weights_valid <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_ternary_weight_loader.sv
// Randomised and directed bench for the ternary weight loader with a queue
// scoreboard fed by a signed-integer reference model of the weight matrix.
module tb_tt_ternary_weight_loader;

    localparam int IN_LEN  = 16;
    localparam int OUT_LEN = 8;
    localparam int NBYTES  = IN_LEN * OUT_LEN / 4;
    localparam int BPR     = OUT_LEN / 4;
    localparam int W       = IN_LEN * OUT_LEN * 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic load_start = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic frame_boundary = 1'b0;
    logic [W-1:0] w_flat;
    logic weights_valid, busy, fmt_err;

    tt_ternary_weight_loader #(.InLen(IN_LEN), .OutLen(OUT_LEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .load_start     (load_start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .frame_boundary (frame_boundary),
        .w_flat         (w_flat),
        .weights_valid  (weights_valid),
        .busy           (busy),
        .fmt_err        (fmt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] w;
        logic         wv;
        logic         bsy;
        logic         ferr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: weights as signed integers -1/0/+1 per matrix element.
    int sh  [IN_LEN][OUT_LEN];
    int act [IN_LEN][OUT_LEN];
    bit m_loading, m_pending, m_wv, m_ferr;
    int m_nrecv;

    localparam logic [W-1:0] ALL_POS = {(W/2){2'b01}};
    localparam logic [W-1:0] ALL_NEG = {(W/2){2'b11}};

    function automatic void model_reset();
        for (int r = 0; r < IN_LEN; r++)
            for (int c = 0; c < OUT_LEN; c++) begin
                sh[r][c]  = 0;
                act[r][c] = 0;
            end
        m_loading = 0; m_pending = 0; m_wv = 0; m_ferr = 0; m_nrecv = 0;
    endfunction

    function automatic logic [W-1:0] active_image();
        logic [W-1:0] img;
        img = '0;
        for (int r = 0; r < IN_LEN; r++)
            for (int c = 0; c < OUT_LEN; c++)
                img[(r*OUT_LEN+c)*2 +: 2] = (act[r][c] == 1) ? 2'b01 :
                                            (act[r][c] == -1) ? 2'b11 : 2'b00;
        return img;
    endfunction

    function automatic void absorb(logic [7:0] d);
        logic [1:0] f;
        int r, c;
        for (int j = 0; j < 4; j++) begin
            f = d[2*j +: 2];
            r = m_nrecv / BPR;
            c = (m_nrecv % BPR) * 4 + j;
            sh[r][c] = (f == 2'b01) ? 1 : (f == 2'b11) ? -1 : 0;
            if (f == 2'b10) m_ferr = 1;
        end
        m_nrecv++;
        if (m_nrecv == NBYTES) begin
            m_loading = 0;
            m_pending = 1;
        end
    endfunction

    function automatic void model_clock(bit ls, bit iv, logic [7:0] d, bit fb);
        if (!en) return;
        if (ls) begin
            m_loading = 1; m_pending = 0; m_nrecv = 0; m_ferr = 0;
            if (iv) absorb(d);
        end else if (m_loading) begin
            if (iv) absorb(d);
        end else if (m_pending && (fb || !m_wv)) begin
            act = sh;
            m_wv = 1;
            m_pending = 0;
        end
    endfunction

    task automatic chk_bus(string name, logic [W-1:0] a, logic [W-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    task automatic chk_bit(string name, logic a, logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    task automatic step(bit ls, bit iv, logic [7:0] d, bit fb);
        exp_t e;
        load_start = ls; in_valid = iv; in_data = d; frame_boundary = fb;
        @(posedge clk);
        if (rst_n) model_clock(ls, iv, d, fb);
        else       model_reset();
        e.w = active_image(); e.wv = m_wv; e.bsy = m_loading | m_pending; e.ferr = m_ferr;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares every registered output cycle against the queued prediction.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_bus("sb w_flat", w_flat, e.w);
                chk_bit("sb weights_valid", weights_valid, e.wv);
                chk_bit("sb busy", busy, e.bsy);
                chk_bit("sb fmt_err", fmt_err, e.ferr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] prev;
        model_reset();
        repeat (2) @(negedge clk);
        chk_bus("reset w_flat", w_flat, '0);
        chk_bit("reset weights_valid", weights_valid, 1'b0);
        chk_bit("reset busy", busy, 1'b0);
        chk_bit("reset fmt_err", fmt_err, 1'b0);
        rst_n = 1'b1;

        // First load commits without waiting for a boundary.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < NBYTES; i++) step(0, 1, 8'h55, 0);
        step(0, 0, 8'h00, 0);
        chk_bus("t1 w_flat", w_flat, ALL_POS);
        chk_bit("t1 weights_valid", weights_valid, 1'b1);

        // Second load must wait for frame_boundary.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < NBYTES; i++) step(0, 1, 8'hFF, 0);
        repeat (3) step(0, 0, 8'h00, 0);
        chk_bit("t2 busy pending", busy, 1'b1);
        chk_bus("t2 w_flat held", w_flat, ALL_POS);
        step(0, 0, 8'h00, 1);
        chk_bus("t2 w_flat commit", w_flat, ALL_NEG);
        chk_bit("t2 busy idle", busy, 1'b0);

        // Illegal code in byte 0.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h02, 0);
        chk_bit("t3 fmt_err set", fmt_err, 1'b1);
        for (int i = 1; i < NBYTES; i++) step(0, 1, 8'($urandom), 0);
        step(0, 0, 8'h00, 1);
        chk_bus("t3 r0c0 zero", W'(w_flat[1:0]), '0);
        step(1, 0, 8'h00, 0);
        chk_bit("t3 fmt_err cleared", fmt_err, 1'b0);

        // Restart after 10 bytes; exactly 32 further bytes complete the load.
        prev = active_image();
        for (int i = 0; i < 10; i++) step(0, 1, 8'($urandom), 0);
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < NBYTES - 1; i++) step(0, 1, 8'h00, 0);
        chk_bit("t4 still loading", busy, 1'b1);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        chk_bit("t4 pending", busy, 1'b1);
        chk_bus("t4 active intact", w_flat, prev);
        step(0, 0, 8'h00, 1);
        chk_bus("t4 commit zeros", w_flat, '0);

        // Enable low mid-load freezes everything.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 8'($urandom), 0);
        en = 1'b0;
        repeat (5) step(0, 1, 8'($urandom), 1);
        en = 1'b1;
        for (int i = 12; i < NBYTES; i++) step(0, 1, 8'($urandom), 0);
        step(0, 0, 8'h00, 1);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            en = (($urandom % 8) != 0);
            step(($urandom % 40) == 0, ($urandom % 4) != 0, 8'($urandom), ($urandom % 6) == 0);
        end
        en = 1'b1;

        // Asynchronous reset in the middle of a load.
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < NBYTES; i++) step(0, 1, 8'h55, 0);
        step(0, 0, 8'h00, 1);
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 8'hFF, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_bus("t6 w_flat", w_flat, '0);
        chk_bit("t6 weights_valid", weights_valid, 1'b0);
        chk_bit("t6 busy", busy, 1'b0);
        chk_bit("t6 fmt_err", fmt_err, 1'b0);
        model_reset();
        @(negedge clk);
        repeat (2) step(0, 1, 8'hFF, 0);
        rst_n = 1'b1;
        repeat (3) step(0, 1, 8'hFF, 0);

        @(negedge clk);
        #1;
        chk_bit("scoreboard drained", q.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
